// File: rtl/aha_clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable sequencer.
package aha_clk_gate_pkg;

    // Life cycle of one gated clock domain.
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PEND   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_IDLE   = 3'd4
    } dom_state_t;

    // Width that holds any settle or stagger reload value.
    function automatic int cnt_width(input int settle, input int stagger);
        return $clog2(((settle > stagger) ? settle : stagger) + 1);
    endfunction

endpackage

// File: rtl/aha_clk_gate_domain_fsm.sv
// One gated domain: waits for a turn-on grant, settles, then holds the
// clock on until it has been idle for the programmed hysteresis.
module aha_clk_gate_domain_fsm
    import aha_clk_gate_pkg::*;
#(
    parameter int IDLE_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              busy,
    input  logic [IDLE_W-1:0] idle_limit,
    input  logic              grant,
    output logic              pend,
    output logic              gate_en,
    output logic              ack
);

    dom_state_t        state;
    dom_state_t        state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  settle_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;

    // Next-state and counter updates; a grant beats a same-cycle request drop
    // and renewed activity beats an idle-limit match.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        idle_nxt   = idle_cnt;
        case (state)
            ST_OFF: begin
                if (req) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (grant) begin
                    state_nxt  = ST_SETTLE;
                    settle_nxt = CNT_W'(SETTLE_CYCLES - 1);
                end else if (!req) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_nxt = ST_ON;
                else                  settle_nxt = settle_cnt - CNT_W'(1);
            end
            ST_ON: begin
                if (!req && !busy) begin
                    state_nxt = ST_IDLE;
                    idle_nxt  = '0;
                end
            end
            ST_IDLE: begin
                if (req || busy)                  state_nxt = ST_ON;
                else if (idle_cnt >= idle_limit)  state_nxt = ST_OFF;
                else                              idle_nxt  = idle_cnt + IDLE_W'(1);
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // State register; enable and acknowledge come straight from flops so the
    // ICG enable pin never sees decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            idle_cnt   <= '0;
            gate_en    <= 1'b0;
            ack        <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            idle_cnt   <= idle_nxt;
            gate_en    <= (state_nxt == ST_SETTLE) || (state_nxt == ST_ON) ||
                          (state_nxt == ST_IDLE);
            ack        <= (state_nxt == ST_ON) || (state_nxt == ST_IDLE);
        end
    end

    assign pend = (state == ST_PEND);

endmodule

// File: rtl/aha_clk_gate_ctrl.sv
// Sequences ICG enables for a bank of gated domains, staggering turn-ons
// through a round-robin arbiter so only one domain wakes per stagger window.
module aha_clk_gate_ctrl
    import aha_clk_gate_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int IDLE_W         = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          SCAN_EN,
    input  logic [NUM_DOMAINS-1:0]        REQ,
    input  logic [NUM_DOMAINS-1:0]        BUSY,
    input  logic [NUM_DOMAINS*IDLE_W-1:0] IDLE_LIMIT,
    output logic [NUM_DOMAINS-1:0]        GATE_EN,
    output logic [NUM_DOMAINS-1:0]        GATE_TE,
    output logic [NUM_DOMAINS-1:0]        ACK
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES, STAGGER_CYCLES);
    localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic [NUM_DOMAINS-1:0] pend;
    logic [NUM_DOMAINS-1:0] grant;
    logic                   grant_valid;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       stagger_cnt;
    int                     idx;

    // Round-robin pick of one pending domain, starting at the pointer, only
    // while the stagger window has expired.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (stagger_cnt == '0) begin
            for (int off = 0; off < NUM_DOMAINS; off++) begin
                idx = (int'(rr_ptr) + off) % NUM_DOMAINS;
                if (!grant_valid && pend[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx[PTR_W-1:0];
                end
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

    // Stagger countdown and pointer advance past the domain just granted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stagger_cnt <= '0;
            rr_ptr      <= '0;
        end else if (grant_valid) begin
            stagger_cnt <= CNT_W'(STAGGER_CYCLES - 1);
            rr_ptr      <= (grant_idx == PTR_W'(NUM_DOMAINS - 1)) ? '0
                                                                  : grant_idx + PTR_W'(1);
        end else if (stagger_cnt != '0) begin
            stagger_cnt <= stagger_cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        aha_clk_gate_domain_fsm #(
            .IDLE_W        (IDLE_W),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_fsm (
            .clk        (CLK),
            .reset      (RESET),
            .req        (REQ[i]),
            .busy       (BUSY[i]),
            .idle_limit (IDLE_LIMIT[i*IDLE_W +: IDLE_W]),
            .grant      (grant[i]),
            .pend       (pend[i]),
            .gate_en    (GATE_EN[i]),
            .ack        (ACK[i])
        );
    end

    assign GATE_TE = {NUM_DOMAINS{SCAN_EN}};

endmodule

// File: tb/tb_aha_clk_gate_ctrl.sv
// Self-checking bench for aha_clk_gate_ctrl: directed scenarios followed by
// randomized traffic, all compared against a timestamp-based reference model.
module tb_aha_clk_gate_ctrl;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int S  = 2;
    localparam int ST = 4;

    logic            CLK;
    logic            RESET;
    logic            SCAN_EN;
    logic [N-1:0]    REQ;
    logic [N-1:0]    BUSY;
    logic [N*IW-1:0] IDLE_LIMIT;
    logic [N-1:0]    GATE_EN;
    logic [N-1:0]    GATE_TE;
    logic [N-1:0]    ACK;

    int errors = 0;
    int checks = 0;

    // Reference model: each domain is described by whether it is waiting for
    // a turn-on slot, whether its clock is enabled, when it was granted and
    // since which edge it has been idle (-1 while active).
    bit           m_wait [N];
    bit           m_en   [N];
    int           m_grant[N];
    int           m_idle [N];
    int           cyc     = 0;
    int           free_at = 0;
    int           ptr     = 0;
    logic [N-1:0] exp_gate = '0;
    logic [N-1:0] exp_ack  = '0;

    aha_clk_gate_ctrl #(
        .NUM_DOMAINS    (N),
        .IDLE_W         (IW),
        .SETTLE_CYCLES  (S),
        .STAGGER_CYCLES (ST)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCAN_EN    (SCAN_EN),
        .REQ        (REQ),
        .BUSY       (BUSY),
        .IDLE_LIMIT (IDLE_LIMIT),
        .GATE_EN    (GATE_EN),
        .GATE_TE    (GATE_TE),
        .ACK        (ACK)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs sampled there.
    task automatic modelStep(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] bsy,
                             input logic [N*IW-1:0] lim);
        int g;
        int dd;
        cyc++;
        if (rst) begin
            for (int d = 0; d < N; d++) begin
                m_wait[d] = 1'b0;
                m_en[d]   = 1'b0;
                m_idle[d] = -1;
            end
            free_at = 0;
            ptr     = 0;
        end else begin
            g = -1;
            if (cyc >= free_at) begin
                for (int k = 0; k < N; k++) begin
                    dd = (ptr + k) % N;
                    if (g < 0 && m_wait[dd]) g = dd;
                end
            end
            if (g >= 0) begin
                free_at = cyc + ST;
                ptr     = (g + 1) % N;
            end
            for (int d = 0; d < N; d++) begin
                if (m_wait[d]) begin
                    if (g == d) begin
                        m_wait[d]  = 1'b0;
                        m_en[d]    = 1'b1;
                        m_grant[d] = cyc;
                        m_idle[d]  = -1;
                    end else if (!rq[d]) begin
                        m_wait[d] = 1'b0;
                    end
                end else if (m_en[d]) begin
                    if (cyc - 1 >= m_grant[d] + S) begin
                        if (m_idle[d] < 0) begin
                            if (!rq[d] && !bsy[d]) m_idle[d] = cyc;
                        end else if (rq[d] || bsy[d]) begin
                            m_idle[d] = -1;
                        end else if ((cyc - 1 - m_idle[d]) >= int'(lim[d*IW +: IW])) begin
                            m_en[d] = 1'b0;
                        end
                    end
                end else if (rq[d]) begin
                    m_wait[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            exp_gate[d] = m_en[d];
            exp_ack[d]  = m_en[d] && (cyc >= m_grant[d] + S);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check the test enable,
    // then compare the registered outputs just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] bsy,
                                 input logic [N*IW-1:0] lim, input logic scan);
        @(negedge CLK);
        RESET      = rst;
        REQ        = rq;
        BUSY       = bsy;
        IDLE_LIMIT = lim;
        SCAN_EN    = scan;
        #1;
        checkOutput("gate_te", 32'(GATE_TE), 32'({N{scan}}));
        @(posedge CLK);
        modelStep(rst, rq, bsy, lim);
        #1;
        checkOutput("gate_en", 32'(GATE_EN), 32'(exp_gate));
        checkOutput("ack", 32'(ACK), 32'(exp_ack));
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        logic [N*IW-1:0] lim;
        logic [N-1:0]    rq_r;
        logic [N-1:0]    bs_r;
        logic [N*IW-1:0] lim_r;
        logic            sc_r;
        logic            rs_r;

        RESET = 1'b1; SCAN_EN = 1'b0; REQ = '0; BUSY = '0; IDLE_LIMIT = '0;
        lim = {N{8'd3}};

        // Reset state.
        applyStimulus(1'b1, 4'b0000, 4'b0000, lim, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, lim, 1'b0);
        checkOutput("reset_gate_en", 32'(GATE_EN), 32'h0);
        checkOutput("reset_ack", 32'(ACK), 32'h0);

        // Single domain: enable one edge after the request is seen, ack two later.
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b0);
        checkOutput("single_pend_gate", 32'(GATE_EN), 32'h0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b0);
        checkOutput("single_grant_gate", 32'(GATE_EN), 32'h1);
        checkOutput("single_settle_ack", 32'(ACK), 32'h0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b0);
        checkOutput("single_settle2_ack", 32'(ACK), 32'h0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b0);
        checkOutput("single_on_ack", 32'(ACK), 32'h1);
        for (int j = 0; j < 8; j++) applyStimulus(1'b0, 4'b0000, 4'b0000, lim, 1'b0);
        checkOutput("single_off_gate", 32'(GATE_EN), 32'h0);

        // Stagger: all domains request together, grants four edges apart.
        applyStimulus(1'b1, 4'b0000, 4'b0000, lim, 1'b0);
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000, lim, 1'b0);
            if (j == 1)  checkOutput("stagger_d0", 32'(GATE_EN), 32'h1);
            if (j == 4)  checkOutput("stagger_hold", 32'(GATE_EN), 32'h1);
            if (j == 5)  checkOutput("stagger_d1", 32'(GATE_EN), 32'h3);
            if (j == 9)  checkOutput("stagger_d2", 32'(GATE_EN), 32'h7);
            if (j == 13) checkOutput("stagger_d3", 32'(GATE_EN), 32'hF);
        end

        // Hysteresis: domain 1 with a limit of 5 drops its clock 7 edges after REQ falls.
        lim[1*IW +: IW] = 8'd5;
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 4'b1101, 4'b0000, lim, 1'b0);
            if (j == 5) checkOutput("hyst_still_on", 32'(GATE_EN[1]), 32'h1);
            if (j == 6) checkOutput("hyst_off", 32'(GATE_EN[1]), 32'h0);
        end

        // Same again with BUSY pulsed three edges into the idle count.
        for (int j = 0; j < 6; j++) applyStimulus(1'b0, 4'b1111, 4'b0000, lim, 1'b0);
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b0, 4'b1101, (j == 3) ? 4'b0010 : 4'b0000, lim, 1'b0);
            if (j == 6)  checkOutput("hyst_busy_extend", 32'(GATE_EN[1]), 32'h1);
            if (j == 10) checkOutput("hyst_busy_off", 32'(GATE_EN[1]), 32'h0);
        end

        // Cancel: a one-cycle request during the stagger window never wins a slot.
        applyStimulus(1'b1, 4'b0000, 4'b0000, lim, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, lim, 1'b1);
        applyStimulus(1'b0, 4'b0011, 4'b0000, lim, 1'b0);
        applyStimulus(1'b0, 4'b0101, 4'b0000, lim, 1'b1);
        applyStimulus(1'b0, 4'b0101, 4'b0000, lim, 1'b0);
        checkOutput("cancel_blocked", 32'(GATE_EN), 32'h1);
        applyStimulus(1'b0, 4'b0101, 4'b0000, lim, 1'b1);
        checkOutput("cancel_next_grant", 32'(GATE_EN), 32'h5);

        // Reset with domains on clears everything and returns the pointer to 0.
        applyStimulus(1'b1, 4'b0101, 4'b0000, lim, 1'b0);
        checkOutput("midreset_gate_en", 32'(GATE_EN), 32'h0);
        checkOutput("midreset_ack", 32'(ACK), 32'h0);
        applyStimulus(1'b0, 4'b1010, 4'b0000, lim, 1'b0);
        applyStimulus(1'b0, 4'b1010, 4'b0000, lim, 1'b0);
        checkOutput("midreset_ptr", 32'(GATE_EN), 32'h2);

        // Randomized traffic with occasional resets and limit changes.
        rq_r  = '0;
        lim_r = lim;
        for (int j = 0; j < 1500; j++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 7) == 0) rq_r[d] = ~rq_r[d];
                bs_r[d] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 31) == 0) lim_r[d*IW +: IW] = 8'($urandom_range(0, 6));
            end
            sc_r = ($urandom_range(0, 3) == 0);
            rs_r = ($urandom_range(0, 149) == 0);
            applyStimulus(rs_r, rq_r, bs_r, lim_r, sc_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
